// File: rtl/filt_out_fifo.sv
// Output buffer behind the FIR filter: captures push strobes into a circular FIFO
// and presents them on a valid/ready port, with sticky drop flagging when full.
module filt_out_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              ovf_q, ovf_d;
    logic              empty, full, pop, write_en, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    always_comb begin
        pop      = ~empty & m_ready;
        write_en = push & (~full | pop);
        drop     = push & full & ~pop;
        wr_ptr_d = write_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop      ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        // m_data is registered: preload the word the next read pointer will address,
        // bypassing the array when that slot is being written on this same edge.
        if (write_en && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0])) begin
            m_data_d = din;
        end else begin
            m_data_d = mem[rd_ptr_d[ADDR_W-1:0]];
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            m_data_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            m_data_q <= m_data_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= din;
        end
    end

    assign m_valid  = ~empty;
    assign m_data   = m_data_q;
    assign level    = wr_ptr_q - rd_ptr_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_filt_out_fifo.sv
// Self-checking bench for filt_out_fifo: directed scenarios plus a random phase,
// all compared against a queue-based reference model.
module tb_filt_out_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              clr_ovf = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] model_q[$];
    logic              model_ovf = 1'b0;

    always #5 clk = ~clk;

    filt_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, model_q.size() > 0});
        chk({tag, ".level"}, 32'(level), 32'(model_q.size()));
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, model_ovf});
        if (model_q.size() > 0) chk({tag, ".m_data"}, 32'(m_data), 32'(model_q[0]));
    endtask

    // One clock: drive inputs, advance the model by the FIFO's rules, compare.
    task automatic cyc(input string tag, input logic p, input logic [DATA_W-1:0] d,
                       input logic r, input logic c);
        bit do_pop, is_full;
        push = p; din = d; m_ready = r; clr_ovf = c;
        @(posedge clk);
        #1;
        do_pop  = r && (model_q.size() > 0);
        is_full = (model_q.size() == DEPTH);
        if (do_pop) void'(model_q.pop_front());
        if (p && (!is_full || do_pop)) model_q.push_back(d);
        if (p && is_full && !do_pop) model_ovf = 1'b1;
        else if (c)                  model_ovf = 1'b0;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] rd;

        // 1: held in reset with random activity on the inputs
        model_reset();
        for (int i = 0; i < 3; i++) begin
            push = 1'($urandom); din = DATA_W'($urandom); m_ready = 1'($urandom);
            @(posedge clk);
            #1;
            check_outputs("rst_hold");
            chk("rst_hold.m_data", 32'(m_data), 32'd0);
        end
        #2 rst = 1'b1;
        cyc("rst_release", 1'b0, '0, 1'b1, 1'b0);

        // 2: single word, held then popped
        cyc("single_push", 1'b1, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("single_hold", 1'b0, '0, 1'b0, 1'b0);
        cyc("single_pop", 1'b0, '0, 1'b1, 1'b0);

        // 3: fill, overflow drop, drain, clear
        for (int i = 1; i <= DEPTH; i++) cyc("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
        cyc("ovf_drop", 1'b1, 16'h0009, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc("drain_ovf", 1'b0, '0, 1'b1, 1'b0);
        cyc("ovf_clear", 1'b0, '0, 1'b0, 1'b1);

        // 4: push and pop together while full
        for (int i = 1; i <= DEPTH; i++) cyc("fill2", 1'b1, DATA_W'(i), 1'b0, 1'b0);
        cyc("full_push_pop", 1'b1, 16'h00AA, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc("drain2", 1'b0, '0, 1'b1, 1'b0);

        // 5: streaming with constant ready, pointers wrap twice
        for (int i = 0; i < 20; i++) cyc("stream", 1'b1, DATA_W'(i), 1'b1, 1'b0);
        cyc("stream_tail", 1'b0, '0, 1'b1, 1'b0);

        // 6: asynchronous reset during a drain
        for (int i = 0; i < 5; i++) cyc("fill5", 1'b1, DATA_W'(16'h0100 + i), 1'b0, 1'b0);
        cyc("drain5", 1'b0, '0, 1'b1, 1'b0);
        push = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #3 rst = 1'b1;
        cyc("post_rst_push", 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cyc("post_rst_pop", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc("fill6", 1'b1, DATA_W'(16'h0200 + i), 1'b0, 1'b0);
        cyc("drop_beats_clr", 1'b1, 16'h0BAD, 1'b0, 1'b1);
        cyc("clr_after", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc("drain6", 1'b0, '0, 1'b1, 1'b0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rd = DATA_W'($urandom);
            cyc("random", 1'($urandom_range(0, 99) < 60), rd,
                1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
